// File: rtl/cpu_clk_pkg.sv
// cpu_clk_pkg: shared run-state encoding and pc_force fill value for the CPU clock/boot block
package cpu_clk_pkg;
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2, STEP = 2'd3} run_state_t;
  localparam logic FORCE_ALL = 1'b1;
endpackage

// File: rtl/cpu_clock_boot_ctrl_clk_div_counter.sv
// clk_div_counter: half-period counter with a pending divide value committed only at wrap
module clk_div_counter #(
  parameter int DIV_W       = 16,
  parameter int DIV_DEFAULT = 1
) (
  input  logic             clk_in,
  input  logic             init_n,
  input  logic             enable,
  input  logic             load,
  input  logic [DIV_W-1:0] value,
  output logic             wrap
);
  logic [DIV_W-1:0] counter, div_q, pend;
  logic pend_v;
  assign wrap = enable && counter == div_q;
  always_ff @(posedge clk_in) begin
    if (!init_n) begin
      counter <= '0;
      div_q   <= DIV_W'(DIV_DEFAULT);
      pend    <= '0;
      pend_v  <= 1'b0;
    end else begin
      counter <= (enable && !wrap) ? counter + 1'b1 : '0;
      // the old pending value commits here even if a new load lands on the same edge
      if (wrap && pend_v) div_q <= pend;
      if (load) pend <= value;
      pend_v <= load | (pend_v & ~wrap);
    end
  end
endmodule

// File: rtl/cpu_clock_boot_ctrl.sv
// cpu_clock_boot_ctrl: divided CPU clock, boot vector forcing, halt/single-step and LED heartbeat
module cpu_clock_boot_ctrl
  import cpu_clk_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int DIV_DEFAULT = 1,
  parameter int ADDR_W      = 15,
  parameter int BOOT_CYCLES = 4,
  parameter int LED_DIV     = 1
) (
  input  logic              clk_in,
  input  logic              init_n,
  input  logic              div_load,
  input  logic [DIV_W-1:0]  div_value,
  input  logic              halt,
  input  logic              step_req,
  output logic              cpu_clk,
  output logic              cpu_tick,
  output logic [ADDR_W-1:0] pc_force,
  output logic              boot_done,
  output run_state_t        run_state,
  output logic              led
);
  localparam int BW = $clog2(BOOT_CYCLES + 1);
  localparam int LW = $clog2(LED_DIV + 1);
  run_state_t state, state_d;
  logic [BW-1:0] boot_cnt;
  logic [LW-1:0] led_cnt;
  logic wrap, rise, fall, led_wrap;
  assign rise      = wrap & ~cpu_clk;
  assign fall      = wrap & cpu_clk;
  assign led_wrap  = led_cnt == LW'(LED_DIV - 1);
  assign run_state = state;
  clk_div_counter #(.DIV_W(DIV_W), .DIV_DEFAULT(DIV_DEFAULT)) u_div (
    .clk_in (clk_in),
    .init_n (init_n),
    .enable (state == RUN || state == STEP),
    .load   (div_load),
    .value  (div_value),
    .wrap   (wrap)
  );
  always_comb begin
    state_d = state;
    case (state)
      BOOT: state_d = (boot_cnt == BW'(BOOT_CYCLES - 1)) ? RUN : BOOT;
      RUN:  state_d = (fall && halt) ? HALT : RUN;
      HALT: state_d = step_req ? STEP : (halt ? HALT : RUN);
      STEP: state_d = fall ? (halt ? HALT : RUN) : STEP;
    endcase
  end
  always_ff @(posedge clk_in) begin
    if (!init_n) begin
      state     <= BOOT;
      boot_cnt  <= '0;
      cpu_clk   <= 1'b0;
      cpu_tick  <= 1'b0;
      pc_force  <= {ADDR_W{FORCE_ALL}};
      boot_done <= 1'b0;
      led       <= 1'b0;
      led_cnt   <= '0;
    end else begin
      state    <= state_d;
      boot_cnt <= (state == BOOT) ? boot_cnt + 1'b1 : boot_cnt;
      cpu_clk  <= cpu_clk ^ wrap;
      cpu_tick <= rise;
      if (rise) begin
        pc_force  <= '0;
        boot_done <= 1'b1;
        led       <= led ^ led_wrap;
        led_cnt   <= led_wrap ? '0 : led_cnt + 1'b1;
      end
    end
  end
endmodule
